magnitude_comparator: RTL and testbench
=======================================

# magnitude_comparator

Unsigned magnitude comparator block with two independent paths. The first is a parameterized combinational parallel comparator with cascade inputs, so wider comparators can be chained MSB-stage to LSB-stage. The second is a clocked bit-serial comparator that takes one bit of each operand per clock, MSB first, and keeps a registered greater/equal/less verdict. The block sits in the datapath wherever operands are compared, either word-parallel or as a streamed bit sequence of arbitrary length.

## Interface
Parameters:
- BIT_LEN, default 4: operand width of the combinational path.

Ports:
- clk  input  1  single clock; all sequential logic on the rising edge.
- reset  input  1  reset is synchronous and active-high; it clears the serial verdict to "equal".
- a  input  BIT_LEN  combinational operand A (unsigned).
- b  input  BIT_LEN  combinational operand B (unsigned).
- lgn_in  input  1  cascade input: "A greater" verdict from the more-significant stage. Tie to 0 for the top stage.
- e_in  input  1  cascade input: "equal so far" from the more-significant stage. Tie to 1 for the top stage.
- lgn_out  output  1  combinational: A greater than B, including the cascade.
- e_out  output  1  combinational: A equal to B, including the cascade.
- sa  input  1  serial operand A bit, MSB first.
- sb  input  1  serial operand B bit, MSB first.
- gout  output  1  registered: serial A > B.
- eout  output  1  registered: serial A == B so far.
- lout  output  1  registered: serial A < B.

## Operation
Combinational path (no state):
- If e_in = 0: lgn_out = lgn_in and e_out = 0. The upper stage has already decided the result.
- If e_in = 1:
  - lgn_out = (a > b), unsigned.
  - e_out = (a == b).
  - lgn_in is ignored.
- The combination e_in = 1, lgn_in = 1 is invalid upstream; it is handled by the rule above and never flagged.
- "Less" is not an output. It is derived downstream as !lgn_out & !e_out.

Serial path, three registered flags g/e/l:
- The flags are one-hot at all times. Legal states are EQ(0,1,0), GT(1,0,0) and LT(0,0,1).
- EQ with sa=1, sb=0 → GT.
- EQ with sa=0, sb=1 → LT.
- EQ with sa==sb → stays EQ.
- GT and LT are absorbing: the first differing bit decides the result and later bits are ignored, until reset.
- Stream length is unbounded. There is no bit counter, so streams of 1..N bits are all valid, and the name "4bit" is historical.
- gout/eout/lout drive directly from the flags.

## Timing
- Combinational path: zero latency, purely combinational from a, b, lgn_in, e_in.
- Serial path: sa/sb are sampled on each rising clk edge with reset=0. The updated verdict is visible immediately after that edge, so latency is 1 cycle per bit.
- Reset:
  - Synchronous, active-high. On any rising edge with reset=1 the flags go to EQ (gout=0, eout=1, lout=0) regardless of sa/sb.
  - Reset has priority over a simultaneous bit.
  - Reset mid-stream discards the verdict, and the next non-reset edge takes the MSB of a new stream.
- Before the first reset edge the outputs are undefined. The bench must assert reset before use.
- Holding reset for multiple cycles keeps EQ.

## Test plan
- Combinational, top stage (lgn_in=0, e_in=1, BIT_LEN=4):
  - a=9, b=3 → lgn_out=1, e_out=0.
  - a=5, b=5 → lgn_out=0, e_out=1.
  - a=2, b=14 → lgn_out=0, e_out=0.
- Combinational cascade: e_in=0, lgn_in=1, a=0, b=15 → lgn_out=1, e_out=0. Then e_in=0, lgn_in=0, a=15, b=0 → lgn_out=0, e_out=0.
- Serial reset: reset=1 for one edge → gout=0, eout=1, lout=0. Then bits (1,1), (0,0) → still EQ after each edge.
- Serial decide-and-hold: after reset, bits (1,1), (1,0) → GT after the 2nd edge. Then (0,1), (0,1) → remains GT.
- Serial less-than: after reset, bits (0,1) → LT after the 1st edge. Then reset=1 together with sa=1, sb=0 → EQ, not GT.
- Random regression: 16 streams of 1..20 random bits, each preceded by reset. Check the one-hot flags against a reference MSB-first compare after every edge.

Source files
------------

// File: rtl/magnitude_comparator.sv
// ---------------------------------------------------------------------------
// magnitude_comparator
//
// Unsigned magnitude comparison with two independent paths:
//   * A combinational word-parallel comparator with cascade inputs. Stages
//     are chained MSB-stage to LSB-stage to build wider comparators.
//   * A clocked bit-serial comparator. It consumes one bit of each operand
//     per clock, MSB first, and holds a registered greater/equal/less verdict.
//
// Parameters:
//   BIT_LEN  operand width of the combinational path (default 4)
//
// Ports:
//   clk      rising-edge clock for the serial path
//   reset    synchronous, active-high; forces the serial verdict to "equal"
//   a, b     combinational operands (unsigned, BIT_LEN bits)
//   lgn_in   cascade "A greater" from the more-significant stage (0 at top)
//   e_in     cascade "equal so far" from the more-significant stage (1 at top)
//   lgn_out  combinational A > B, including the cascade
//   e_out    combinational A == B, including the cascade
//   sa, sb   serial operand bits, MSB first
//   gout     registered serial A > B
//   eout     registered serial A == B so far
//   lout     registered serial A < B
// ---------------------------------------------------------------------------
module magnitude_comparator #(
    parameter int BIT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BIT_LEN-1:0] a,
    input  logic [BIT_LEN-1:0] b,
    input  logic               lgn_in,
    input  logic               e_in,
    output logic               lgn_out,
    output logic               e_out,
    input  logic               sa,
    input  logic               sb,
    output logic               gout,
    output logic               eout,
    output logic               lout
);

    // -----------------------------------------------------------------------
    // Combinational path
    // -----------------------------------------------------------------------
    // When the upper stage has already seen a difference (e_in = 0), its
    // verdict passes straight through. Otherwise this stage decides locally.
    // lgn_in is ignored while e_in = 1, so the invalid upstream combination
    // e_in = 1 / lgn_in = 1 resolves to the local compare.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no
        // latch is inferred.
        lgn_out = lgn_in;
        e_out   = 1'b0;
        if (e_in) begin
            lgn_out = (a > b);
            e_out   = (a == b);
        end
    end

    // -----------------------------------------------------------------------
    // Serial path
    // -----------------------------------------------------------------------
    // The verdict is encoded one-hot as {g, e, l}. The state register bits
    // themselves are the outputs, so the outputs are glitch-free and the
    // one-hot property holds by construction.
    typedef enum logic [2:0] {
        ST_GT = 3'b100,
        ST_EQ = 3'b010,
        ST_LT = 3'b001
    } verdict_e;

    verdict_e verdict_d;
    verdict_e verdict_q;

    // GT and LT are absorbing: only EQ looks at the incoming bits. The first
    // differing bit of the stream decides the result.
    always_comb begin
        verdict_d = verdict_q;
        if (verdict_q == ST_EQ) begin
            if (sa && !sb) begin
                verdict_d = ST_GT;
            end else if (!sa && sb) begin
                verdict_d = ST_LT;
            end
        end
    end

    // Reset has priority over a bit presented on the same edge; the next
    // non-reset edge then takes the MSB of a new stream.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its input from before the edge.
        if (reset) begin
            verdict_q <= ST_EQ;
        end else begin
            verdict_q <= verdict_d;
        end
    end

    assign gout = verdict_q[2];
    assign eout = verdict_q[1];
    assign lout = verdict_q[0];

endmodule

// File: tb/tb_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_magnitude_comparator
//
// Directed test of both comparator paths. Each task drives its own stimulus
// and checks the outputs inline against hand-computed values. The random
// regression checks the serial verdict against an integer compare of the
// stream prefixes. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_magnitude_comparator;

    localparam int BIT_LEN = 4;

    logic               clk;
    logic               reset;
    logic [BIT_LEN-1:0] a;
    logic [BIT_LEN-1:0] b;
    logic               lgn_in;
    logic               e_in;
    logic               lgn_out;
    logic               e_out;
    logic               sa;
    logic               sb;
    logic               gout;
    logic               eout;
    logic               lout;

    int n_checks;
    int n_fail;

    magnitude_comparator #(.BIT_LEN(BIT_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .lgn_in  (lgn_in),
        .e_in    (e_in),
        .lgn_out (lgn_out),
        .e_out   (e_out),
        .sa      (sa),
        .sb      (sb),
        .gout    (gout),
        .eout    (eout),
        .lout    (lout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one serial bit (or a reset) and wait until just after the edge.
    task automatic serial_step(input logic rst, input logic bit_a, input logic bit_b);
        reset = rst;
        sa    = bit_a;
        sb    = bit_b;
        @(posedge clk);
        #1;
    endtask

    // Apply combinational inputs and let them settle.
    task automatic comb_apply(input logic [BIT_LEN-1:0] va, input logic [BIT_LEN-1:0] vb,
                              input logic lin, input logic ein);
        a      = va;
        b      = vb;
        lgn_in = lin;
        e_in   = ein;
        #1;
    endtask

    task automatic test_comb_top();
        logic [1:0] exp_v [3];
        logic [3:0] va    [3];
        logic [3:0] vb    [3];
        va[0] = 4'd9;  vb[0] = 4'd3;  exp_v[0] = 2'b10;
        va[1] = 4'd5;  vb[1] = 4'd5;  exp_v[1] = 2'b01;
        va[2] = 4'd2;  vb[2] = 4'd14; exp_v[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            comb_apply(va[i], vb[i], 1'b0, 1'b1);
            n_checks++;
            if ({lgn_out, e_out} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL comb_top a=%0d b=%0d: got lgn/e=%b, expected %b",
                         va[i], vb[i], {lgn_out, e_out}, exp_v[i]);
            end
        end
    endtask

    task automatic test_comb_cascade();
        comb_apply(4'd0, 4'd15, 1'b1, 1'b0);
        n_checks++;
        if ({lgn_out, e_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL comb_cascade_gt: got lgn/e=%b, expected 10", {lgn_out, e_out});
        end
        comb_apply(4'd15, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if ({lgn_out, e_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL comb_cascade_lt: got lgn/e=%b, expected 00", {lgn_out, e_out});
        end
        // Invalid upstream combination: lgn_in ignored while e_in = 1.
        comb_apply(4'd3, 4'd3, 1'b1, 1'b1);
        n_checks++;
        if ({lgn_out, e_out} !== 2'b01) begin
            n_fail++;
            $display("FAIL comb_invalid_eq: got lgn/e=%b, expected 01", {lgn_out, e_out});
        end
        comb_apply(4'd1, 4'd8, 1'b1, 1'b1);
        n_checks++;
        if ({lgn_out, e_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL comb_invalid_lt: got lgn/e=%b, expected 00", {lgn_out, e_out});
        end
    endtask

    // Full sweep of the top-stage compare over all 4-bit operand pairs.
    task automatic test_comb_sweep();
        int va_i;
        int vb_i;
        logic [1:0] exp_v;
        for (int i = 0; i < 256; i++) begin
            va_i = i / 16;
            vb_i = i % 16;
            comb_apply(va_i[3:0], vb_i[3:0], 1'b0, 1'b1);
            exp_v = {(va_i > vb_i), (va_i == vb_i)};
            n_checks++;
            if ({lgn_out, e_out} !== exp_v) begin
                n_fail++;
                $display("FAIL comb_sweep a=%0d b=%0d: got lgn/e=%b, expected %b",
                         va_i, vb_i, {lgn_out, e_out}, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        serial_step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({gout, eout, lout} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset: got gel=%b, expected 010", {gout, eout, lout});
        end
        // Held reset stays EQ even with a differing bit present.
        serial_step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({gout, eout, lout} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_hold: got gel=%b, expected 010", {gout, eout, lout});
        end
        serial_step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({gout, eout, lout} !== 3'b010) begin
            n_fail++;
            $display("FAIL eq_bit11: got gel=%b, expected 010", {gout, eout, lout});
        end
        serial_step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({gout, eout, lout} !== 3'b010) begin
            n_fail++;
            $display("FAIL eq_bit00: got gel=%b, expected 010", {gout, eout, lout});
        end
    endtask

    task automatic test_serial_hold();
        logic [1:0] bits  [5];
        logic [2:0] exp_v [5];
        bits[0] = 2'b11; exp_v[0] = 3'b010;
        bits[1] = 2'b10; exp_v[1] = 3'b100;
        bits[2] = 2'b01; exp_v[2] = 3'b100;
        bits[3] = 2'b01; exp_v[3] = 3'b100;
        bits[4] = 2'b00; exp_v[4] = 3'b100;
        serial_step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            serial_step(1'b0, bits[i][1], bits[i][0]);
            n_checks++;
            if ({gout, eout, lout} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL serial_hold bit%0d: got gel=%b, expected %b",
                         i, {gout, eout, lout}, exp_v[i]);
            end
        end
    endtask

    task automatic test_serial_lt();
        serial_step(1'b1, 1'b0, 1'b0);
        serial_step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({gout, eout, lout} !== 3'b001) begin
            n_fail++;
            $display("FAIL serial_lt: got gel=%b, expected 001", {gout, eout, lout});
        end
        serial_step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({gout, eout, lout} !== 3'b001) begin
            n_fail++;
            $display("FAIL serial_lt_hold: got gel=%b, expected 001", {gout, eout, lout});
        end
        // Reset wins over a simultaneous GT bit.
        serial_step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({gout, eout, lout} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_priority: got gel=%b, expected 010", {gout, eout, lout});
        end
        // The next non-reset edge starts a fresh stream.
        serial_step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({gout, eout, lout} !== 3'b100) begin
            n_fail++;
            $display("FAIL new_stream_gt: got gel=%b, expected 100", {gout, eout, lout});
        end
    endtask

    // Reference: integer compare of the MSB-first prefixes seen so far.
    task automatic test_random();
        int         len;
        logic [31:0] av;
        logic [31:0] bv;
        logic        ba;
        logic        bb;
        logic [2:0]  exp_v;
        for (int s = 0; s < 16; s++) begin
            len = $urandom_range(1, 20);
            serial_step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if ({gout, eout, lout} !== 3'b010) begin
                n_fail++;
                $display("FAIL rand_reset s%0d: got gel=%b, expected 010", s, {gout, eout, lout});
            end
            av = '0;
            bv = '0;
            for (int i = 0; i < len; i++) begin
                // Bias towards equal bits so decisions land at varied depths.
                ba = 1'($urandom_range(0, 1));
                bb = ($urandom_range(0, 3) == 0) ? ~ba : ba;
                serial_step(1'b0, ba, bb);
                av = {av[30:0], ba};
                bv = {bv[30:0], bb};
                exp_v = (av > bv) ? 3'b100 : ((av == bv) ? 3'b010 : 3'b001);
                n_checks++;
                if ({gout, eout, lout} !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand s%0d bit%0d: got gel=%b, expected %b",
                             s, i, {gout, eout, lout}, exp_v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        sa       = 1'b0;
        sb       = 1'b0;
        a        = '0;
        b        = '0;
        lgn_in   = 1'b0;
        e_in     = 1'b1;
        @(negedge clk);
        test_comb_top();
        test_comb_cascade();
        test_comb_sweep();
        test_reset();
        test_serial_hold();
        test_serial_lt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the run is bounded even if stimulus stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
